sd_init_sequencer: RTL

SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

---
 rtl/sd_init_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD9.
// Drives a command engine and strobes captured registers into the card-register file.
module sd_init_sequencer #(
  parameter int          ACMD41_MAX_TRIES = 1000,
  parameter logic [31:0] OCR_ARG          = 32'h40FF8000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  input  logic         resp_valid,
  input  logic         resp_timeout,
  input  logic [127:0] resp_data,
  output logic [127:0] reg_wdata,
  output logic         cid_en,
  output logic         ocr_en,
  output logic         rca_en,
  output logic         csd_en,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   err_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CMD0   = 4'd1,
    S_CMD8   = 4'd2,
    S_CMD55  = 4'd3,
    S_ACMD41 = 4'd4,
    S_CMD2   = 4'd5,
    S_CMD3   = 4'd6,
    S_CMD9   = 4'd7,
    S_DONE   = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        in_wait;
  logic        go;
  logic        adv;
  logic        fail;
  logic        fin;
  logic        clr;
  logic        hs;
  logic        rv;
  logic [15:0] tries;
  logic [15:0] rca;
  logic [15:0] rca_nx;
  logic [16:0] tries_inc;

  function automatic logic [5:0] idx_of(state_t s);
    case (s)
      S_CMD8:   idx_of = 6'd8;
      S_CMD55:  idx_of = 6'd55;
      S_ACMD41: idx_of = 6'd41;
      S_CMD2:   idx_of = 6'd2;
      S_CMD3:   idx_of = 6'd3;
      S_CMD9:   idx_of = 6'd9;
      default:  idx_of = 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] arg_of(state_t s,
                                         logic [15:0] r);
    case (s)
      S_CMD8:   arg_of = 32'h0000_01AA;
      S_ACMD41: arg_of = OCR_ARG;
      S_CMD9:   arg_of = {r, 16'h0};
      default:  arg_of = 32'h0;
    endcase
  endfunction

  assign hs        = cmd_valid & cmd_ready;
  assign rv        = in_wait & resp_valid & ~resp_timeout;
  assign tries_inc = {1'b0, tries} + 17'd1;
  // CMD9 is launched on the same edge that captures the RCA
  assign rca_nx    = (state == S_CMD3) ? resp_data[31:16] : rca;

  always_comb begin
    nxt  = state;
    go   = 1'b0;
    adv  = 1'b0;
    fail = 1'b0;
    fin  = 1'b0;
    clr  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          nxt = S_CMD0;
          go  = 1'b1;
          clr = 1'b1;
        end
      end
      default: begin
        if (!in_wait) begin
          if (hs) begin
            if (state == S_CMD0) begin
              nxt = S_CMD8;
              go  = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end
        end else if (resp_timeout) begin
          fail = 1'b1;
        end else if (resp_valid) begin
          case (state)
            S_CMD8: begin
              if (resp_data[11:0] == 12'h1AA) begin
                nxt = S_CMD55;
                go  = 1'b1;
              end else begin
                fail = 1'b1;
              end
            end
            S_CMD55: begin
              nxt = S_ACMD41;
              go  = 1'b1;
            end
            S_ACMD41: begin
              if (resp_data[31]) begin
                nxt = S_CMD2;
                go  = 1'b1;
              end else if (tries_inc ==
                           17'(ACMD41_MAX_TRIES)) begin
                fail = 1'b1;
              end else begin
                nxt = S_CMD55;
                go  = 1'b1;
              end
            end
            S_CMD2: begin
              nxt = S_CMD3;
              go  = 1'b1;
            end
            S_CMD3: begin
              nxt = S_CMD9;
              go  = 1'b1;
            end
            S_CMD9:  fin = 1'b1;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_wait   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      reg_wdata <= '0;
      cid_en    <= 1'b0;
      ocr_en    <= 1'b0;
      rca_en    <= 1'b0;
      csd_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_state <= '0;
      tries     <= '0;
      rca       <= '0;
    end else begin
      cid_en <= 1'b0;
      ocr_en <= 1'b0;
      rca_en <= 1'b0;
      csd_en <= 1'b0;
      if (clr) begin
        done      <= 1'b0;
        error     <= 1'b0;
        err_state <= '0;
        tries     <= '0;
        rca       <= '0;
      end
      if (go) begin
        state     <= nxt;
        in_wait   <= 1'b0;
        cmd_valid <= 1'b1;
        cmd_index <= idx_of(nxt);
        cmd_arg   <= arg_of(nxt, rca_nx);
        busy      <= 1'b1;
      end
      if (adv) begin
        in_wait   <= 1'b1;
        cmd_valid <= 1'b0;
      end
      if (fail) begin
        state     <= S_ERR;
        in_wait   <= 1'b0;
        cmd_valid <= 1'b0;
        busy      <= 1'b0;
        error     <= 1'b1;
        err_state <= state;
      end
      if (fin) begin
        state     <= S_DONE;
        in_wait   <= 1'b0;
        cmd_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end
      if (rv) begin
        case (state)
          S_ACMD41: begin
            if (resp_data[31]) begin
              ocr_en    <= 1'b1;
              reg_wdata <= {96'b0, resp_data[31:0]};
            end else begin
              tries <= tries_inc[15:0];
            end
          end
          S_CMD2: begin
            cid_en    <= 1'b1;
            reg_wdata <= resp_data;
          end
          S_CMD3: begin
            rca       <= resp_data[31:16];
            rca_en    <= 1'b1;
            reg_wdata <= {112'b0, resp_data[31:16]};
          end
          S_CMD9: begin
            csd_en    <= 1'b1;
            reg_wdata <= resp_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
